// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter in front of a single-port data RAM with a fixed read latency.
// Ports:
//   clk, RSTN                 clock, asynchronous active-low reset
//   mX_req/we/addr/wdata      request from master X (0 = CPU bus, 1 = loader/debug)
//   mX_gnt                    one-cycle pulse: request accepted
//   mX_rvalid/rdata           one-cycle read-valid pulse; rdata holds the last read for that master
//   ram_we/addr/din           registered RAM command
//   ram_dout                  RAM read data, valid RD_LAT cycles after the address
//   busy                      high while an access is in progress
module ram_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [9:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [9:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        ram_we,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WR, RD, RET} state_t;

    localparam logic [1:0] LAST_CNT = 2'(RD_LAT);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_gnt_q, last_gnt_d;
    logic        owner_q, owner_d;
    logic        win;
    logic        ram_we_q, ram_we_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic [31:0] ram_din_q, ram_din_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rvalid_q, rvalid_d;

    // On a conflict the master that did not win last time goes first.
    assign win = (m0_req && m1_req) ? ~last_gnt_q : m1_req;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        case (state_q)
            IDLE: if (m0_req || m1_req) begin
                owner_d    = win;
                last_gnt_d = win;
                gnt_d      = win ? 2'b10 : 2'b01;
                ram_we_d   = win ? m1_we : m0_we;
                ram_addr_d = win ? m1_addr : m0_addr;
                ram_din_d  = win ? m1_wdata : m0_wdata;
                cnt_d      = 2'd0;
                state_d    = (win ? m1_we : m0_we) ? WR : RD;
            end
            WR: state_d = IDLE;
            // Address has been on the RAM since entry; after RD_LAT+1 cycles the
            // data is settled and RET samples it.
            RD: if (cnt_q == LAST_CNT) state_d = RET;
                else cnt_d = cnt_q + 2'd1;
            RET: begin
                rvalid_d   = owner_q ? 2'b10 : 2'b01;
                m0_rdata_d = owner_q ? m0_rdata_q : ram_dout;
                m1_rdata_d = owner_q ? ram_dout : m1_rdata_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= 10'd0;
            ram_din_q  <= 32'd0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized scoreboard bench for ram_arbiter (RD_LAT=1) plus a directed RD_LAT=3 instance.
module tb_ram_arbiter;
    localparam int RD_LAT = 1;

    typedef struct { logic we; logic [9:0] addr; logic [31:0] data; } op_t;
    typedef struct { logic m; logic we; logic [9:0] addr; logic [31:0] din; logic [31:0] rd; } exp_t;
    typedef struct { logic m; logic [31:0] data; int due; } rd_t;

    logic        clk, RSTN;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we, busy;
    logic [31:0] m0_rdata, m1_rdata, ram_din, ram_dout;
    logic [9:0]  ram_addr;

    logic        m0_req3, m0_we3;
    logic [9:0]  m0_addr3;
    logic [31:0] m0_wdata3;
    logic        m0_gnt3, m1_gnt3, m0_rvalid3, m1_rvalid3, ram_we3, busy3;
    logic [31:0] m0_rdata3, m1_rdata3, ram_din3, ram_dout3;
    logic [9:0]  ram_addr3;

    ram_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .RSTN(RSTN),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy)
    );

    ram_arbiter #(.RD_LAT(3)) u3 (
        .clk(clk), .RSTN(RSTN),
        .m0_req(m0_req3), .m0_we(m0_we3), .m0_addr(m0_addr3), .m0_wdata(m0_wdata3),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(10'd0), .m1_wdata(32'd0),
        .m0_gnt(m0_gnt3), .m1_gnt(m1_gnt3), .m0_rvalid(m0_rvalid3), .m1_rvalid(m1_rvalid3),
        .m0_rdata(m0_rdata3), .m1_rdata(m1_rdata3),
        .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_din(ram_din3), .ram_dout(ram_dout3),
        .busy(busy3)
    );

    // Power-up content of a never-written RAM word.
    function automatic logic [31:0] dflt(input logic [9:0] a);
        return {6'h2A, a, 6'h15, a};
    endfunction

    // RAM stubs: storage plus a read pipeline of the configured depth.
    logic [31:0] mem [1024];
    bit          wrote [1024];
    logic [31:0] pipe [RD_LAT];
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]   <= ram_din;
            wrote[ram_addr] <= 1'b1;
        end
        pipe[0] <= wrote[ram_addr] ? mem[ram_addr] : dflt(ram_addr);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        p3[0] <= dflt(ram_addr3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ram_dout  = pipe[RD_LAT-1];
    assign ram_dout3 = p3[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [int];
    logic        model_last = 1'b1;
    logic [31:0] mrd [2] = '{32'd0, 32'd0};
    int          busy_until = 0, last_gnt_cyc = -1;
    bit          spacing = 1'b0;
    exp_t        exp_q [$];
    rd_t         rd_q [$];
    op_t         ops0 [$], ops1 [$];

    function automatic logic [31:0] ref_rd(input logic [9:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    task automatic push_exp(input logic m, input op_t o, input logic [31:0] rd);
        exp_t e;
        e.m = m; e.we = o.we; e.addr = o.addr; e.din = o.data; e.rd = rd;
        exp_q.push_back(e);
    endtask

    // Grant order from the rules: both pending -> the one not granted last; otherwise whoever is left.
    task automatic predict();
        int i0 = 0, i1 = 0;
        logic w;
        op_t o;
        while (i0 < ops0.size() || i1 < ops1.size()) begin
            w = (i0 < ops0.size() && i1 < ops1.size()) ? !model_last : (i1 < ops1.size());
            if (w) begin o = ops1[i1]; i1++; end
            else   begin o = ops0[i0]; i0++; end
            model_last = w;
            if (o.we) ref_mem[int'(o.addr)] = o.data;
            push_exp(w, o, ref_rd(o.addr));
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows a grant or read data.
    always @(negedge clk) begin : mon
        exp_t e;
        rd_t  r;
        logic ew;
        if (RSTN) begin
            ew = 1'b0;
            chk("gnt_exclusive", 32'(m0_gnt & m1_gnt), 32'd0);
            if (m0_gnt | m1_gnt) begin
                if (exp_q.size() == 0) chk("gnt_unexpected", 32'({m1_gnt, m0_gnt}), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("gnt_master", 32'({m1_gnt, m0_gnt}), e.m ? 32'd2 : 32'd1);
                    chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                    chk("ram_din", ram_din, e.din);
                    if (spacing && last_gnt_cyc >= 0) chk("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'd2);
                    last_gnt_cyc = cyc;
                    ew = e.we;
                    busy_until = cyc + (e.we ? 1 : RD_LAT + 2);
                    if (!e.we) begin
                        r.m = e.m; r.data = e.rd; r.due = cyc + RD_LAT + 2;
                        rd_q.push_back(r);
                    end
                end
            end
            chk("ram_we", 32'(ram_we), 32'(ew));
            chk("busy", 32'(busy), 32'(cyc < busy_until));
            if (m0_rvalid | m1_rvalid) begin
                if (rd_q.size() == 0) chk("rvalid_unexpected", 32'({m1_rvalid, m0_rvalid}), 32'd0);
                else begin
                    r = rd_q.pop_front();
                    chk("rvalid_master", 32'({m1_rvalid, m0_rvalid}), r.m ? 32'd2 : 32'd1);
                    chk("rvalid_cycle", 32'(cyc), 32'(r.due));
                    mrd[r.m] = r.data;
                end
            end
            if (rd_q.size() != 0 && cyc > rd_q[0].due) begin
                chk("rvalid_missing", 32'(cyc), 32'(rd_q[0].due));
                void'(rd_q.pop_front());
            end
            chk("m0_rdata", m0_rdata, mrd[0]);
            chk("m1_rdata", m1_rdata, mrd[1]);
        end
    end

    task automatic drive(input logic m);
        op_t o;
        int  t;
        while ((m ? ops1.size() : ops0.size()) != 0) begin
            o = m ? ops1[0] : ops0[0];
            if (m) begin m1_we = o.we; m1_addr = o.addr; m1_wdata = o.data; m1_req = 1'b1; end
            else   begin m0_we = o.we; m0_addr = o.addr; m0_wdata = o.data; m0_req = 1'b1; end
            t = 0;
            do begin @(posedge clk); #1; t++; end while (!(m ? m1_gnt : m0_gnt) && t < 200);
            if (!(m ? m1_gnt : m0_gnt)) begin
                chk(m ? "m1_gnt_timeout" : "m0_gnt_timeout", 32'd0, 32'd1);
                if (m) ops1.delete(); else ops0.delete();
            end else if (m) void'(ops1.pop_front());
            else void'(ops0.pop_front());
        end
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0 || busy) && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 100) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_txn();
        predict();
        fork
            drive(1'b0);
            drive(1'b1);
        join
        wait_idle();
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        exp_q.delete();
        rd_q.delete();
        model_last = 1'b1;
        mrd[0] = 32'd0;
        mrd[1] = 32'd0;
        busy_until = 0;
        last_gnt_cyc = -1;
    endtask

    function automatic op_t mk(input logic we, input logic [9:0] a, input logic [31:0] d);
        op_t o;
        o.we = we; o.addr = a; o.data = d;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk(1'($urandom_range(1)),
                  $urandom_range(1) ? 10'($urandom_range(15)) : 10'($urandom), $urandom);
    endfunction

    initial begin
        int issue_cyc, nb, rv_at;
        op_t o;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        m0_req3 = 0; m0_we3 = 0; m0_addr3 = 0; m0_wdata3 = 0;
        do_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        @(posedge clk); #1;
        RSTN = 1'b1;

        // Latency-3 instance: single read, busy for 5 cycles, rvalid 5 cycles after gnt
        m0_addr3 = 10'h123; m0_we3 = 1'b0; m0_wdata3 = $urandom; m0_req3 = 1'b1;
        @(posedge clk); #1;
        chk("lat3_gnt", 32'(m0_gnt3), 32'd1);
        m0_req3 = 1'b0;
        nb = 0; rv_at = -1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (busy3) nb++;
            if (m0_rvalid3) rv_at = k;
        end
        chk("lat3_busy_cycles", 32'(nb), 32'd5);
        chk("lat3_rvalid_cycle", 32'(rv_at), 32'd5);
        chk("lat3_rdata", m0_rdata3, dflt(10'h123));

        // Both masters read right after reset: m0 first, then m1
        ops0.push_back(mk(1'b0, 10'h021, $urandom));
        ops1.push_back(mk(1'b0, 10'h022, $urandom));
        run_txn();

        // m0 write then read back
        ops0.push_back(mk(1'b1, 10'h005, 32'hDEADBEEF));
        ops0.push_back(mk(1'b0, 10'h005, 32'h0));
        run_txn();
        chk("wr_rd_m0_rdata", m0_rdata, 32'hDEADBEEF);

        // Continuous back-to-back writes from both: alternate, one grant per 2 cycles
        for (int i = 0; i < 6; i++) begin
            ops0.push_back(mk(1'b1, 10'($urandom_range(15)), $urandom));
            ops1.push_back(mk(1'b1, 10'($urandom_range(15)), $urandom));
        end
        spacing = 1'b1;
        last_gnt_cyc = -1;
        run_txn();
        spacing = 1'b0;

        // m1 read must not disturb m0_rdata
        ops1.push_back(mk(1'b1, 10'h3FF, 32'h12345678));
        run_txn();
        ops0.push_back(mk(1'b1, 10'h010, 32'hAAAA5555));
        ops0.push_back(mk(1'b0, 10'h010, 32'h0));
        run_txn();
        ops1.push_back(mk(1'b0, 10'h3FF, 32'h0));
        run_txn();
        chk("isol_m1_rdata", m1_rdata, 32'h12345678);
        chk("isol_m0_rdata", m0_rdata, 32'hAAAA5555);

        // Request raised and withdrawn while busy: never granted
        ops0.push_back(mk(1'b0, 10'($urandom), $urandom));
        predict();
        drive(1'b0);
        m1_we = 1'b1; m1_addr = 10'($urandom); m1_wdata = $urandom; m1_req = 1'b1;
        @(posedge clk); #1;
        m1_req = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        // Randomized mixes
        for (int n = 0; n < 40; n++) begin
            int n0 = $urandom_range(3), n1 = $urandom_range(3);
            if (n0 + n1 == 0) n0 = 1;
            for (int i = 0; i < n0; i++) ops0.push_back(rand_op());
            for (int i = 0; i < n1; i++) ops1.push_back(rand_op());
            run_txn();
        end

        // Reset during RD: abort, no rvalid afterwards, rdata cleared
        o = mk(1'b0, 10'h00A, $urandom);
        push_exp(1'b0, o, 32'd0);
        ops0.push_back(o);
        drive(1'b0);
        #2;
        do_reset();
        #1;
        chk("abort_rd_busy", 32'(busy), 32'd0);
        chk("abort_rd_ram_we", 32'(ram_we), 32'd0);
        chk("abort_rd_m0_rdata", m0_rdata, 32'd0);
        chk("abort_rd_m1_rdata", m1_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        RSTN = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Reset during WR: ram_we drops at once and the word is not written
        o = mk(1'b1, 10'h3FE, 32'hFEEDF00D);
        push_exp(1'b1, o, 32'd0);
        ops1.push_back(o);
        drive(1'b1);
        #2;
        do_reset();
        #1;
        chk("abort_wr_ram_we", 32'(ram_we), 32'd0);
        chk("abort_wr_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        RSTN = 1'b1;

        // First arbitration right on the first edge after reset release
        issue_cyc = cyc;
        ops1.push_back(mk(1'b0, 10'h3FE, $urandom));
        run_txn();
        chk("first_arb_cycle", 32'(last_gnt_cyc), 32'(issue_cyc + 1));
        chk("aborted_wr_not_stored", m1_rdata, dflt(10'h3FE));

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
